// File: rtl/hex_convert_seq.sv
// Sequential 16-bit hex to 5-digit packed-BCD converter (double-dabble), also exposing binary and octal forms.
// Define HEX_CONV_OCTAL_EN to build the octal output register; otherwise out_octal is tied to zero.
module hex_convert_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_hex,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_binary,
    output logic [17:0] out_octal,
    output logic [19:0] out_bcd,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] shreg;
    logic [19:0] bcd;
    logic [3:0]  count;
    logic [15:0] binary_q;
    logic [19:0] bcd_q;

    logic        accept;
    logic        last_shift;
    logic        handshake;
    logic [19:0] bcd_adj;
    logic [35:0] shifted;

    assign accept     = in_valid && in_ready;
    assign last_shift = (state == SHIFT) && (count == 4'd0);
    assign handshake  = (state == DONE) && out_ready;

    // in_ready is gated by rst_n so it reads 0 for the whole reset interval, not just after the first edge.
    assign in_ready   = (state == IDLE) && rst_n;
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_binary = binary_q;
    assign out_bcd    = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (handshake)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Per-digit add-3 is 4-bit wide with no carry between digits.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 5; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {bcd_adj, shreg} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bcd      <= '0;
            count    <= '0;
            binary_q <= '0;
            bcd_q    <= '0;
        end else if (accept) begin
            shreg    <= in_hex;
            bcd      <= '0;
            count    <= 4'd15;
            binary_q <= in_hex;
        end else if (state == SHIFT) begin
            shreg <= shifted[15:0];
            bcd   <= shifted[35:16];
            count <= count - 4'd1;
            if (count == 4'd0) begin
                bcd_q <= shifted[35:16];
            end
        end
    end

`ifdef HEX_CONV_OCTAL_EN
    logic [17:0] octal_q;

    // A zero-extended binary word is already a concatenation of 3-bit octal digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            octal_q <= '0;
        end else if (accept) begin
            octal_q <= {2'b00, in_hex};
        end
    end

    assign out_octal = octal_q;
`else
    assign out_octal = 18'h0;
`endif

endmodule

// File: tb/tb_hex_convert_seq.sv
// Self-checking bench for hex_convert_seq: directed cases plus random words against an arithmetic reference model.
module tb_hex_convert_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_hex = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_binary;
    logic [17:0] out_octal;
    logic [19:0] out_bcd;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_accept = 0;

    hex_convert_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_hex     (in_hex),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_binary (out_binary),
        .out_octal  (out_octal),
        .out_bcd    (out_bcd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Decimal digits by repeated division, packed four bits per digit.
    function automatic logic [19:0] refBcd(input int value);
        logic [19:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [17:0] refOctal(input int value);
        logic [17:0] r;
        int v;
        r = '0;
        v = value;
`ifdef HEX_CONV_OCTAL_EN
        for (int d = 0; d < 6; d++) begin
            r[3*d +: 3] = 3'(v % 8);
            v = v / 8;
        end
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", tag, actual, expected, cycle);
        end
    endtask

    // Called at a negedge; performs one accept, waits for the result, stalls, then consumes it.
    task automatic applyStimulus(input logic [15:0] value, input int stall, input bit keep_valid);
        int waited;
        int acc;
        logic [19:0] exp_bcd;
        logic [17:0] exp_oct;
        exp_bcd = refBcd(int'(value));
        exp_oct = refOctal(int'(value));
        in_hex = value;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        acc = cycle + 1;
        last_accept = acc;
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        @(negedge clk);
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("latency", 32'(cycle - acc + 1), 32'd17);
        checkOutput("bcd", 32'(out_bcd), 32'(exp_bcd));
        checkOutput("binary", 32'(out_binary), 32'(value));
        checkOutput("octal", 32'(out_octal), 32'(exp_oct));
        checkOutput("ready_while_valid", 32'(in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_bcd", 32'(out_bcd), 32'(exp_bcd));
            checkOutput("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("idle_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_acc;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_bcd", 32'(out_bcd), 32'd0);
        checkOutput("reset_binary", 32'(out_binary), 32'd0);
        checkOutput("reset_octal", 32'(out_octal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_ready", 32'(in_ready), 32'd1);

        applyStimulus(16'h270F, 0, 1'b0);
        applyStimulus(16'hFFFF, 1, 1'b0);
        applyStimulus(16'h0000, 0, 1'b0);
        applyStimulus(16'h00FF, 10, 1'b0);

        // Back-to-back with in_valid held high throughout.
        applyStimulus(16'h0001, 0, 1'b1);
        first_acc = last_accept;
        applyStimulus(16'h000A, 0, 1'b0);
        checkOutput("accept_period", 32'(last_accept - first_acc), 32'd18);

        // Reset in the middle of a conversion.
        in_hex = 16'h00FF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_bcd", 32'(out_bcd), 32'd0);
        checkOutput("midreset_binary", 32'(out_binary), 32'd0);
        checkOutput("midreset_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h1234, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
